// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared stage encodings, opcode classes and defaults for the ARM-LP stage sequencer.
package cpu_stage_sequencer_pkg;

   typedef enum logic [2:0] {
      STAGE_IDLE      = 3'd0,
      STAGE_FETCH     = 3'd1,
      STAGE_DECODE    = 3'd2,
      STAGE_EXECUTE   = 3'd3,
      STAGE_MEMORY    = 3'd4,
      STAGE_WRITEBACK = 3'd5,
      STAGE_HALTED    = 3'd6
   } stage_t;

   typedef enum logic [2:0] {
      CLASS_RALU = 3'd0,
      CLASS_IALU = 3'd1,
      CLASS_LDUR = 3'd2,
      CLASS_STUR = 3'd3,
      CLASS_CBZ  = 3'd4,
      CLASS_B    = 3'd5,
      CLASS_NOP  = 3'd6,
      CLASS_HALT = 3'd7
   } op_class_t;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

   function automatic logic is_busy_stage(input stage_t s);
      return (s == STAGE_FETCH) || (s == STAGE_DECODE) || (s == STAGE_EXECUTE) ||
             (s == STAGE_MEMORY) || (s == STAGE_WRITEBACK);
   endfunction

endpackage

// File: rtl/cpu_stage_sequencer_perf_counter_sat.sv
// Saturating up-counter with synchronous clear; clear dominates increment.
module perf_counter_sat #(
   parameter int unsigned W = 32
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clock) begin
      if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with one-hot stage enables,
// data-cache wait handling with timeout, and bring-up cycle/retire counters.
module cpu_stage_sequencer
   import cpu_stage_sequencer_pkg::*;
#(
   parameter int unsigned CYCLE_W     = 32,
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic [2:0]         opcodeClass,
   input  logic               memReady,
   output logic               fetchEnable,
   output logic               decodeEnable,
   output logic               executeEnable,
   output logic               memEnable,
   output logic               writebackEnable,
   output logic               pcUpdateEnable,
   output logic [2:0]         stage,
   output logic               busy,
   output logic               halted,
   output logic               timeoutError,
   output logic [CYCLE_W-1:0] cycleCount,
   output logic [CYCLE_W-1:0] retiredCount
);

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   stage_t    state, next_state;
   op_class_t cls;
   logic [7:0] tmo_cnt;
   logic      retire, tmo_hit;

   always_comb begin
      next_state = state;
      retire     = 1'b0;
      tmo_hit    = 1'b0;
      case (state)
         STAGE_IDLE:   if (run) next_state = STAGE_FETCH;
         STAGE_FETCH:  next_state = STAGE_DECODE;
         STAGE_DECODE: next_state = (opcodeClass == CLASS_HALT) ? STAGE_HALTED : STAGE_EXECUTE;
         STAGE_EXECUTE: begin
            case (cls)
               CLASS_LDUR, CLASS_STUR: next_state = STAGE_MEMORY;
               CLASS_RALU, CLASS_IALU: next_state = STAGE_WRITEBACK;
               default: begin
                  retire     = 1'b1;
                  next_state = run ? STAGE_FETCH : STAGE_IDLE;
               end
            endcase
         end
         STAGE_MEMORY: begin
            if (memReady) begin
               if (cls == CLASS_LDUR) begin
                  next_state = STAGE_WRITEBACK;
               end else begin
                  retire     = 1'b1;
                  next_state = run ? STAGE_FETCH : STAGE_IDLE;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit    = 1'b1;
               next_state = STAGE_HALTED;
            end
         end
         STAGE_WRITEBACK: begin
            retire     = 1'b1;
            next_state = run ? STAGE_FETCH : STAGE_IDLE;
         end
         STAGE_HALTED: next_state = STAGE_HALTED;
         default:      next_state = STAGE_IDLE;
      endcase
   end

   // Outputs are registered from next_state so they always decode the current state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= STAGE_IDLE;
         cls             <= CLASS_RALU;
         tmo_cnt         <= '0;
         timeoutError    <= 1'b0;
         fetchEnable     <= 1'b0;
         decodeEnable    <= 1'b0;
         executeEnable   <= 1'b0;
         memEnable       <= 1'b0;
         writebackEnable <= 1'b0;
         busy            <= 1'b0;
         halted          <= 1'b0;
      end else begin
         state <= next_state;
         if (state == STAGE_DECODE)
            cls <= op_class_t'(opcodeClass);
         if (state != STAGE_MEMORY)
            tmo_cnt <= '0;
         else if (!memReady)
            tmo_cnt <= tmo_cnt + 8'd1;
         if (tmo_hit)
            timeoutError <= 1'b1;
         fetchEnable     <= (next_state == STAGE_FETCH);
         decodeEnable    <= (next_state == STAGE_DECODE);
         executeEnable   <= (next_state == STAGE_EXECUTE);
         memEnable       <= (next_state == STAGE_MEMORY);
         writebackEnable <= (next_state == STAGE_WRITEBACK);
         busy            <= is_busy_stage(next_state);
         halted          <= (next_state == STAGE_HALTED);
      end
   end

   assign stage          = state;
   assign pcUpdateEnable = retire & ~reset;

   perf_counter_sat #(.W(CYCLE_W)) u_cycle_cnt (
      .clock (clock),
      .clear (reset),
      .inc   (busy),
      .count (cycleCount)
   );

   perf_counter_sat #(.W(CYCLE_W)) u_retired_cnt (
      .clock (clock),
      .clear (reset),
      .inc   (retire),
      .count (retiredCount)
   );

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Table-driven, scoreboarded bench for cpu_stage_sequencer.
module tb_cpu_stage_sequencer;
   import cpu_stage_sequencer_pkg::*;

   logic        clock = 1'b0;
   logic        reset, run, memReady;
   logic [2:0]  opcodeClass;
   logic        fetchEnable, decodeEnable, executeEnable, memEnable, writebackEnable;
   logic        pcUpdateEnable, busy, halted, timeoutError;
   logic [2:0]  stage;
   logic [31:0] cycleCount, retiredCount;

   cpu_stage_sequencer #(.CYCLE_W(32), .MEM_TIMEOUT(15)) dut (
      .clock           (clock),
      .reset           (reset),
      .run             (run),
      .opcodeClass     (opcodeClass),
      .memReady        (memReady),
      .fetchEnable     (fetchEnable),
      .decodeEnable    (decodeEnable),
      .executeEnable   (executeEnable),
      .memEnable       (memEnable),
      .writebackEnable (writebackEnable),
      .pcUpdateEnable  (pcUpdateEnable),
      .stage           (stage),
      .busy            (busy),
      .halted          (halted),
      .timeoutError    (timeoutError),
      .cycleCount      (cycleCount),
      .retiredCount    (retiredCount)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  stage;
      logic        pc;
      logic        tmo;
      logic [31:0] cyc;
      logic [31:0] ret;
   } rec_t;

   typedef struct {
      logic [2:0]  cls;
      int unsigned n_mem;
      int unsigned lat;
   } vec_t;

   rec_t        sb[$];
   rec_t        r;
   vec_t        vecs[10];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] m_cyc, m_ret;
   logic        m_tmo;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] exp_en(input logic [2:0] s);
      case (s)
         3'd1:    return 5'b10000;
         3'd2:    return 5'b01000;
         3'd3:    return 5'b00100;
         3'd4:    return 5'b00010;
         3'd5:    return 5'b00001;
         default: return 5'b00000;
      endcase
   endfunction

   always @(negedge clock) begin
      if (sb.size() != 0) begin
         r = sb.pop_front();
         check("stage", stage, r.stage);
         check("pcUpdateEnable", pcUpdateEnable, r.pc);
         check("enables", {fetchEnable, decodeEnable, executeEnable, memEnable, writebackEnable},
               exp_en(r.stage));
         check("busy", busy, (r.stage >= 3'd1 && r.stage <= 3'd5));
         check("halted", halted, (r.stage == 3'd6));
         check("timeoutError", timeoutError, r.tmo);
         check("cycleCount", cycleCount, r.cyc);
         check("retiredCount", retiredCount, r.ret);
      end
   end

   task automatic push_rec(input logic [2:0] s, input logic pc);
      rec_t e;
      e.stage = s; e.pc = pc; e.tmo = m_tmo; e.cyc = m_cyc; e.ret = m_ret;
      sb.push_back(e);
      if (s >= 3'd1 && s <= 3'd5) m_cyc++;
      if (pc) m_ret++;
   endtask

   task automatic push_instr(input logic [2:0] cls, input int unsigned n_mem, input int unsigned lat);
      logic [2:0] seq[$];
      seq.push_back(3'd1); seq.push_back(3'd2); seq.push_back(3'd3);
      for (int unsigned i = 0; i < n_mem; i++) seq.push_back(3'd4);
      if (cls <= 3'd2) seq.push_back(3'd5);
      foreach (seq[i]) push_rec(seq[i], (i == int'(lat) - 1));
   endtask

   // k: 0 FETCH, 1 DECODE, 2 EXECUTE, 3.. MEMORY; class only valid in DECODE, junk elsewhere.
   task automatic drive(input logic [2:0] cls, input int n_mem, input int cycles, input int run_low_at);
      for (int k = 0; k < cycles; k++) begin
         opcodeClass = (k == 1) ? cls : 3'($urandom_range(0, 7));
         memReady    = (n_mem == 0) ? 1'($urandom_range(0, 1)) : (k == 2 + n_mem);
         if (k == run_low_at) run = 1'b0;
         @(posedge clock); #1;
      end
   endtask

   task automatic start_after_reset();
      reset = 1'b1; run = 1'b0; memReady = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0; run = 1'b1;
      m_cyc = '0; m_ret = '0; m_tmo = 1'b0;
      @(posedge clock); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{3'd0, 0, 4};
      vecs[1] = '{3'd1, 0, 4};
      vecs[2] = '{3'd4, 0, 3};
      vecs[3] = '{3'd5, 0, 3};
      vecs[4] = '{3'd6, 0, 3};
      vecs[5] = '{3'd2, 1, 5};
      vecs[6] = '{3'd2, 3, 7};
      vecs[7] = '{3'd3, 1, 4};
      vecs[8] = '{3'd3, 2, 5};
      vecs[9] = '{3'd0, 0, 4};
      m_cyc = '0; m_ret = '0; m_tmo = 1'b0;

      reset = 1'b1; run = 1'b0; memReady = 1'b0; opcodeClass = 3'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_stage", stage, 3'd0);
      check("reset_enables", {fetchEnable, decodeEnable, executeEnable, memEnable, writebackEnable,
            pcUpdateEnable}, 6'd0);
      check("reset_flags", {busy, halted, timeoutError}, 3'd0);
      check("reset_cycleCount", cycleCount, 32'd0);
      check("reset_retiredCount", retiredCount, 32'd0);
      reset = 1'b0; run = 1'b1;
      @(posedge clock); #1;

      foreach (vecs[i]) begin
         push_instr(vecs[i].cls, vecs[i].n_mem, vecs[i].lat);
         drive(vecs[i].cls, int'(vecs[i].n_mem), int'(vecs[i].lat), -1);
      end

      // run dropped during EXECUTE of an I-ALU: instruction completes, then IDLE
      push_instr(3'd1, 0, 4);
      drive(3'd1, 0, 4, 2);
      push_rec(3'd0, 1'b0);
      run = 1'b1;
      @(posedge clock); #1;

      // NOP retires, then HALT stops after DECODE and ignores run
      push_instr(3'd6, 0, 3);
      drive(3'd6, 0, 3, -1);
      push_rec(3'd1, 1'b0); push_rec(3'd2, 1'b0);
      repeat (3) push_rec(3'd6, 1'b0);
      drive(3'd7, 0, 2, -1);
      for (int k = 0; k < 3; k++) begin
         run = ~run; opcodeClass = 3'($urandom_range(0, 7));
         @(posedge clock); #1;
      end

      // store never acknowledged: 15 MEMORY cycles then HALTED with timeoutError
      start_after_reset();
      push_instr(3'd3, 15, 99);
      m_tmo = 1'b1;
      repeat (3) push_rec(3'd6, 1'b0);
      drive(3'd3, 1000, 18, -1);
      for (int k = 0; k < 3; k++) begin
         run = ~run; memReady = 1'b1;
         @(posedge clock); #1;
      end

      // reset in 2nd MEMORY cycle of a store whose ack arrives the same cycle
      start_after_reset();
      push_instr(3'd3, 1, 99);
      push_rec(3'd4, 1'b0);
      m_cyc = '0; m_ret = '0; m_tmo = 1'b0;
      push_rec(3'd0, 1'b0);
      drive(3'd3, 1000, 4, -1);
      reset = 1'b1; memReady = 1'b1; run = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0; memReady = 1'b0;
      @(posedge clock); #1;

      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
- Multi-cycle control sequencer for the ARM-LP datapath: ALU, DataCache, Controller, InstructionCache, OperationPrep and PC.
- Replaces free-running single-cycle operation with a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM that issues one-hot stage enables.
- Waits on a data-cache ready handshake, guards memory access with a timeout, and keeps cycle and retired-instruction counters for bring-up.

Parameters:
- CYCLE_W, 32: width of cycleCount and retiredCount.
- MEM_TIMEOUT, 15: MEMORY cycles allowed without memReady before abort; legal range 1..255.

Ports:
- clock  in  1  processor clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; wins over every other input.
- run  in  1  level; high lets the sequencer start or continue issuing instructions.
- opcodeClass  in  3  from Controller, valid in DECODE: 0 R-ALU, 1 I-ALU, 2 LDUR, 3 STUR, 4 CBZ, 5 B, 6 NOP, 7 HALT.
- memReady  in  1  DataCache access complete; sampled only in MEMORY.
- fetchEnable  out  1  InstructionCache read at PC.
- decodeEnable  out  1  Controller and OperationPrep latch.
- executeEnable  out  1  ALU operand capture.
- memEnable  out  1  DataCache access window.
- writebackEnable  out  1  gates regWriteFlag into OperationPrep.
- pcUpdateEnable  out  1  one-cycle pulse; PC advances or branches.
- stage  out  3  current state encoding.
- busy  out  1  state is not IDLE and not HALTED.
- halted  out  1  state is HALTED.
- timeoutError  out  1  sticky memory-timeout flag.
- cycleCount  out  CYCLE_W  cycles spent busy; saturates at all-ones.
- retiredCount  out  CYCLE_W  instructions completed; saturates.

Behaviour:
- Reset values:
  - state IDLE (0).
  - All enables, busy, halted and timeoutError 0.
  - cycleCount, retiredCount, latched class and timeout counter 0.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEMORY 4, WRITEBACK 5, HALTED 6. Value 7 is illegal and recovers to IDLE on the next edge.
- Enables are Moore outputs, one-hot by state: fetchEnable=FETCH, decodeEnable=DECODE, executeEnable=EXECUTE, memEnable=MEMORY, writebackEnable=WRITEBACK.
- opcodeClass is registered at the end of DECODE. Changes in opcodeClass outside DECODE are ignored.
- Transitions:
  - IDLE: to FETCH if run, else stay.
  - FETCH: to DECODE unconditionally.
  - DECODE: class 7 to HALTED; all other classes to EXECUTE.
  - EXECUTE:
    - Classes 2 and 3 go to MEMORY.
    - Classes 0 and 1 go to WRITEBACK.
    - Classes 4, 5 and 6 retire: to FETCH if run, else IDLE.
  - MEMORY with memReady: class 2 to WRITEBACK; class 3 retires.
  - MEMORY without memReady: stay and increment the timeout counter.
    - If the counter reaches MEM_TIMEOUT, set timeoutError and go to HALTED without retiring.
  - WRITEBACK: retires, then to FETCH if run, else IDLE.
  - HALTED: held until reset. run is ignored.
- Retire means, in the same cycle:
  - pcUpdateEnable is combinationally high for that one cycle.
  - retiredCount increments.
  - Retirement occurs in the last cycle of each instruction.
- Instruction latencies in cycles:
  - R-ALU and I-ALU: 4.
  - CBZ, B and NOP: 3.
  - STUR: 3+N; LDUR: 4+N, where N ≥ 1 is the number of MEMORY cycles.
  - HALT: 2, never retires, and no pcUpdateEnable.
- The timeout counter clears on entering MEMORY.
- memReady in the first MEMORY cycle means N=1.
- run low mid-instruction: the current instruction completes, then the FSM returns to IDLE. The sequencer never aborts on run.
- cycleCount increments on every edge where busy is high.
- reset asserted mid-instruction: every output takes its reset value at the next edge, including the sticky timeoutError. No pcUpdateEnable is issued.

Decomposition:
- Shared package: stage encodings (STAGE_IDLE..STAGE_HALTED), opcode class constants (CLASS_RALU..CLASS_HALT), and a MEM_TIMEOUT default constant.
- One natural sub-module, perf_counter_sat: a CYCLE_W saturating counter with sync clear. It is instantiated twice, once for cycleCount and once for retiredCount.
- The FSM and the timeout counter stay in the top module.

Test Plan:
- Reset and start: reset for 2 cycles, run=1, class 0 → stages 1,2,3,5 in sequence; pcUpdateEnable high only in cycle 4; retiredCount=1; cycleCount=4.
- Branch path: class 4, run=1 → stages 1,2,3 then back to FETCH; pcUpdateEnable in EXECUTE; memEnable and writebackEnable never high.
- Load with wait states: class 2, memReady rising after 3 MEMORY cycles → memEnable high for exactly 3 cycles, WRITEBACK follows, latency 7, retiredCount +1.
- Store timeout: class 3, memReady=0, MEM_TIMEOUT=15 → after 15 MEMORY cycles timeoutError=1, halted=1, retiredCount unchanged, run toggling has no effect.
- HALT and run drop: class 6 then class 7 → NOP retires, HALT enters HALTED after DECODE. Separately, run dropped during EXECUTE of class 1 → WRITEBACK completes, then IDLE, busy=0.
- Reset mid-MEMORY: reset asserted in the 2nd MEMORY cycle → next edge stage=0, all enables 0, counters 0, and no pcUpdateEnable pulse.
